mem_responder: RTL and testbench
================================

MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, word-address width (memory holds 2^ADDR_W 32-bit words).
REQ-002 SHALL have parameter LINE_WORDS, default 4, beats per line burst (power of two, >=2).
REQ-003 SHALL have parameter LATENCY, default 8, access delay in cycles (>=1).
REQ-004 SHALL have port clk  input  1  single clock, all state on posedge.
REQ-005 SHALL have port rst_n  input  1  reset, asynchronous assert, active-low.
REQ-006 SHALL have port req_valid  input  1  request present.
REQ-007 SHALL have port req_ready  output  1  responder can accept a request.
REQ-008 SHALL have port req_write  input  1  1 = line write, 0 = line read.
REQ-009 SHALL have port req_addr  input  ADDR_W  word address; low log2(LINE_WORDS) bits ignored.
REQ-010 SHALL have port wdata_valid  input  1  write beat present.
REQ-011 SHALL have port wdata_ready  output  1  write beat accepted.
REQ-012 SHALL have port wdata  input  32  write beat data.
REQ-013 SHALL have port rsp_valid  output  1  read beat present.
REQ-014 SHALL have port rsp_ready  input  1  requester accepts read beat.
REQ-015 SHALL have port rsp_data  output  32  read beat data.
REQ-016 SHALL have port rsp_last  output  1  final read beat of burst.
REQ-017 SHALL have port wr_done  output  1  one-cycle pulse, write line committed.

Function
REQ-018 SHALL implement FSM states IDLE, WDATA, WAIT, RDATA, WDONE.
REQ-019 SHALL assert req_ready only in IDLE; request accepted when req_valid & req_ready on a clock edge; req_write and aligned line address latched then.
REQ-020 SHALL go IDLE->WAIT on accepted read, IDLE->WDATA on accepted write.
REQ-021 SHALL assert wdata_ready only in WDATA; each wdata_valid & wdata_ready edge writes wdata to word {line, beat} and increments beat counter; beats arriving outside WDATA are ignored.
REQ-022 SHALL go WDATA->WAIT after beat LINE_WORDS-1 is accepted; idle cycles (wdata_valid low) inside WDATA stall without timeout.
REQ-023 SHALL stay in WAIT exactly LATENCY cycles, then go to RDATA (read) or WDONE (write).
REQ-024 SHALL drive rsp_valid high throughout RDATA with rsp_data = word {line, beat}; rsp_last high when beat = LINE_WORDS-1.
REQ-025 SHALL hold rsp_data/rsp_last stable while rsp_valid & !rsp_ready; advance beat only on rsp_valid & rsp_ready.
REQ-026 SHALL go RDATA->IDLE on handshake of last beat; WDONE asserts wr_done for one cycle then returns to IDLE.
REQ-027 SHALL make beat addresses ascend from offset 0 without wrap across lines; beat counter wraps to 0 at burst end.
REQ-028 SHALL return, for a read following a completed write to the same line, the written data (write commits before wr_done).
REQ-029 SHALL keep memory contents zero at time 0 and not alter them on reset.

Reset
REQ-030 SHALL on rst_n low immediately force state IDLE, beat and latency counters 0, rsp_valid 0, rsp_last 0, wr_done 0, wdata_ready 0, req_ready 1 after release, rsp_data 0.
REQ-031 SHALL abandon any in-flight burst on reset mid-operation; write beats already accepted remain in memory, remaining beats are not written.

Structure
REQ-032 SHALL take the state enum, default ADDR_W/LINE_WORDS/LATENCY constants and beat-index width from shared package mem_pkg.
REQ-033 SHALL place storage in one sub-module mem_array (32-bit words, one sync write port, one async read port).

Verification
REQ-034 SHALL cover: write line addr 0x010, beats 0xA0..0xA3 -> wr_done pulse exactly LATENCY+1 cycles after last beat; read 0x010 -> rsp_data 0xA0,0xA1,0xA2,0xA3 with rsp_last on 4th.
REQ-035 SHALL cover: read addr 0x013 (unaligned) -> beats from words 0x010..0x013, same as aligned read.
REQ-036 SHALL cover: rsp_ready low 3 cycles on beat 2 -> rsp_data held at beat 2 value, no beat skipped or duplicated.
REQ-037 SHALL cover: wdata_valid gaps of 2 cycles between beats -> all 4 beats written, WAIT starts after 4th beat.
REQ-038 SHALL cover: rst_n low during WAIT of a read -> all outputs reset values within same cycle, req_ready high after release, memory unchanged.
REQ-039 SHALL cover: req_valid held high during a burst -> second request accepted only on first IDLE cycle after previous completes.

Source files
------------

// File: rtl/mem_pkg.sv
// Shared types and default constants for the line-burst memory responder.
package mem_pkg;

    localparam int ADDR_W_DEF     = 10;
    localparam int LINE_WORDS_DEF = 4;
    localparam int LATENCY_DEF    = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        WDATA = 3'd1,
        WAIT  = 3'd2,
        RDATA = 3'd3,
        WDONE = 3'd4
    } state_t;

    // Width of the beat index within a line.
    function automatic int beat_w(input int line_words);
        return $clog2(line_words);
    endfunction

    localparam int BEAT_W_DEF = beat_w(LINE_WORDS_DEF);

endpackage

// File: rtl/mem_array.sv
// Word storage: one synchronous write port, one asynchronous read port.
module mem_array
    import mem_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              we,
    input  logic [ADDR_W-1:0] waddr,
    input  logic [31:0]       wdata,
    input  logic [ADDR_W-1:0] raddr,
    output logic [31:0]       rdata
);

    // Contents start at zero and are deliberately untouched by reset.
    logic [31:0] mem [0:(1<<ADDR_W)-1] = '{default: '0};

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/mem_responder.sv
// Line-burst memory responder: accepts a read or write line request, waits a
// fixed access latency, then streams read beats or pulses write completion.
module mem_responder
    import mem_pkg::*;
#(
    parameter int ADDR_W     = ADDR_W_DEF,
    parameter int LINE_WORDS = LINE_WORDS_DEF,
    parameter int LATENCY    = LATENCY_DEF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [ADDR_W-1:0] req_addr,
    input  logic              wdata_valid,
    output logic              wdata_ready,
    input  logic [31:0]       wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [31:0]       rsp_data,
    output logic              rsp_last,
    output logic              wr_done
);

    localparam int BW     = beat_w(LINE_WORDS);
    localparam int LINE_W = ADDR_W - BW;
    localparam int LAT_W  = (LATENCY > 1) ? $clog2(LATENCY) : 1;

    localparam logic [BW-1:0]    LAST_BEAT = BW'(LINE_WORDS - 1);
    localparam logic [LAT_W-1:0] LAT_LAST  = LAT_W'(LATENCY - 1);

    state_t             state, state_nxt;
    logic [BW-1:0]      beat, beat_nxt;
    logic [LAT_W-1:0]   lat_cnt, lat_nxt;
    logic [LINE_W-1:0]  line, line_nxt;
    logic               is_write, write_nxt;
    logic               mem_we;
    logic [31:0]        mem_rdata;

    // Word offset bits of the request address are intentionally ignored.
    logic unused_offset;
    assign unused_offset = ^req_addr[BW-1:0];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            beat     <= '0;
            lat_cnt  <= '0;
            line     <= '0;
            is_write <= 1'b0;
        end else begin
            state    <= state_nxt;
            beat     <= beat_nxt;
            lat_cnt  <= lat_nxt;
            line     <= line_nxt;
            is_write <= write_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        beat_nxt  = beat;
        lat_nxt   = lat_cnt;
        line_nxt  = line;
        write_nxt = is_write;
        mem_we    = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    line_nxt  = req_addr[ADDR_W-1:BW];
                    write_nxt = req_write;
                    beat_nxt  = '0;
                    lat_nxt   = '0;
                    state_nxt = req_write ? WDATA : WAIT;
                end
            end
            WDATA: begin
                if (wdata_valid) begin
                    mem_we   = 1'b1;
                    beat_nxt = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        lat_nxt   = '0;
                        state_nxt = WAIT;
                    end
                end
            end
            WAIT: begin
                if (lat_cnt == LAT_LAST) begin
                    lat_nxt   = '0;
                    state_nxt = is_write ? WDONE : RDATA;
                end else begin
                    lat_nxt = lat_cnt + 1'b1;
                end
            end
            RDATA: begin
                if (rsp_ready) begin
                    beat_nxt = beat + 1'b1;
                    if (beat == LAST_BEAT) begin
                        state_nxt = IDLE;
                    end
                end
            end
            WDONE: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // All handshake outputs decode from state so reset clears them at once.
    assign req_ready   = (state == IDLE);
    assign wdata_ready = (state == WDATA);
    assign rsp_valid   = (state == RDATA);
    assign rsp_last    = (state == RDATA) && (beat == LAST_BEAT);
    assign rsp_data    = (state == RDATA) ? mem_rdata : 32'd0;
    assign wr_done     = (state == WDONE);

    mem_array #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk   (clk),
        .we    (mem_we),
        .waddr ({line, beat}),
        .wdata (wdata),
        .raddr ({line, beat}),
        .rdata (mem_rdata)
    );

endmodule

// File: tb/tb_mem_responder.sv
// Directed bench for mem_responder with hand-computed expected beats.
module tb_mem_responder;

    localparam int LATENCY = 8;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [9:0]  req_addr;
    logic        wdata_valid;
    logic        wdata_ready;
    logic [31:0] wdata;
    logic        rsp_valid;
    logic        rsp_ready;
    logic [31:0] rsp_data;
    logic        rsp_last;
    logic        wr_done;

    int n_vec = 0;
    int n_err = 0;

    mem_responder #(
        .ADDR_W     (10),
        .LINE_WORDS (4),
        .LATENCY    (LATENCY)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_write   (req_write),
        .req_addr    (req_addr),
        .wdata_valid (wdata_valid),
        .wdata_ready (wdata_ready),
        .wdata       (wdata),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_data    (rsp_data),
        .rsp_last    (rsp_last),
        .wr_done     (wr_done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #300000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Presents a request at a falling edge; it is taken on the next rising edge.
    task automatic issue(input logic [9:0] addr, input logic wr, input logic hold);
        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        @(negedge clk);
        chk("accept_rdy", {31'd0, req_ready}, 32'd0);
        if (!hold) req_valid = 1'b0;
    endtask

    task automatic write_line(input logic [9:0] addr, input logic [31:0] base, input int gap);
        int cnt;
        // A beat offered while idle must be ignored.
        wdata_valid = 1'b1;
        wdata       = 32'hBAD0_0000;
        issue(addr, 1'b1, 1'b0);
        chk("wready_on", {31'd0, wdata_ready}, 32'd1);
        for (int b = 0; b < 4; b++) begin
            wdata_valid = 1'b1;
            wdata       = base + 32'(b);
            @(negedge clk);
            wdata_valid = 1'b0;
            if (b < 3) begin
                for (int g = 0; g < gap; g++) begin
                    chk("wgap_ready", {31'd0, wdata_ready}, 32'd1);
                    @(negedge clk);
                end
            end
        end
        chk("wait_start", {31'd0, wdata_ready}, 32'd0);
        // Beats offered during the latency wait must also be ignored.
        wdata_valid = 1'b1;
        wdata       = 32'hDEAD_BEEF;
        cnt = 1;
        while (!wr_done && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("wr_done_lat", 32'(cnt), 32'(LATENCY + 1));
        @(negedge clk);
        wdata_valid = 1'b0;
        chk("wr_done_pulse", {31'd0, wr_done}, 32'd0);
        chk("wr_idle_rdy", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic read_beats(input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3,
                              input int stall_beat, input int stall_n);
        logic [31:0] e[4];
        int cnt;
        e[0] = e0; e[1] = e1; e[2] = e2; e[3] = e3;
        rsp_ready = 1'b1;
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("rd_lat", 32'(cnt), 32'(LATENCY));
        for (int b = 0; b < 4; b++) begin
            chk("rd_valid", {31'd0, rsp_valid}, 32'd1);
            chk("rd_data", rsp_data, e[b]);
            chk("rd_last", {31'd0, rsp_last}, (b == 3) ? 32'd1 : 32'd0);
            chk("busy_rdy", {31'd0, req_ready}, 32'd0);
            if (b == stall_beat) begin
                rsp_ready = 1'b0;
                for (int s = 0; s < stall_n; s++) begin
                    @(negedge clk);
                    chk("stall_valid", {31'd0, rsp_valid}, 32'd1);
                    chk("stall_data", rsp_data, e[b]);
                    chk("stall_last", {31'd0, rsp_last}, (b == 3) ? 32'd1 : 32'd0);
                end
                rsp_ready = 1'b1;
            end
            @(negedge clk);
        end
        chk("rd_end_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rd_idle_rdy", {31'd0, req_ready}, 32'd1);
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rsp_valid"}, {31'd0, rsp_valid}, 32'd0);
        chk({tag, "_rsp_last"}, {31'd0, rsp_last}, 32'd0);
        chk({tag, "_rsp_data"}, rsp_data, 32'd0);
        chk({tag, "_wr_done"}, {31'd0, wr_done}, 32'd0);
        chk({tag, "_wdata_ready"}, {31'd0, wdata_ready}, 32'd0);
    endtask

    task automatic pulse_reset(input string tag);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs(tag);
        @(negedge clk);
        rst_n       = 1'b1;
        req_valid   = 1'b0;
        wdata_valid = 1'b0;
        rsp_ready   = 1'b1;
        #1 chk({tag, "_rdy_release"}, {31'd0, req_ready}, 32'd1);
        @(negedge clk);
    endtask

    initial begin
        int cnt;
        rst_n       = 1'b0;
        req_valid   = 1'b0;
        req_write   = 1'b0;
        req_addr    = '0;
        wdata_valid = 1'b0;
        wdata       = '0;
        rsp_ready   = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("por");
        rst_n = 1'b1;
        @(negedge clk);
        chk("por_req_ready", {31'd0, req_ready}, 32'd1);

        // Basic write then aligned and unaligned reads.
        write_line(10'h010, 32'hA0, 0);
        issue(10'h010, 1'b0, 1'b0);
        read_beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 0);
        issue(10'h013, 1'b0, 1'b0);
        read_beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 0);

        // Back-pressure on beat 2.
        issue(10'h010, 1'b0, 1'b0);
        read_beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, 2, 3);

        // Write with gaps between beats.
        write_line(10'h020, 32'hB0, 2);
        issue(10'h021, 1'b0, 1'b0);
        read_beats(32'hB0, 32'hB1, 32'hB2, 32'hB3, -1, 0);

        // Reset during the latency wait of a read.
        issue(10'h020, 1'b0, 1'b0);
        repeat (3) @(negedge clk);
        pulse_reset("rst_wait");
        issue(10'h020, 1'b0, 1'b0);
        read_beats(32'hB0, 32'hB1, 32'hB2, 32'hB3, -1, 0);

        // Reset while a read beat is stalled.
        issue(10'h020, 1'b0, 1'b0);
        rsp_ready = 1'b0;
        cnt = 0;
        while (!rsp_valid && cnt < 40) begin
            @(negedge clk);
            cnt++;
        end
        chk("rst_rd_valid", {31'd0, rsp_valid}, 32'd1);
        chk("rst_rd_data", rsp_data, 32'hB0);
        pulse_reset("rst_rdata");

        // Reset mid-write: accepted beats stay, the rest are never written.
        issue(10'h030, 1'b1, 1'b0);
        wdata_valid = 1'b1;
        wdata       = 32'hC0;
        @(negedge clk);
        wdata       = 32'hC1;
        @(negedge clk);
        wdata       = 32'hC2;
        pulse_reset("rst_wdata");
        issue(10'h030, 1'b0, 1'b0);
        read_beats(32'hC0, 32'hC1, 32'h0, 32'h0, -1, 0);

        // Request held high through a burst is re-accepted on the first idle cycle.
        issue(10'h010, 1'b0, 1'b1);
        read_beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 0);
        @(negedge clk);
        chk("reaccept_rdy", {31'd0, req_ready}, 32'd0);
        req_valid = 1'b0;
        read_beats(32'hA0, 32'hA1, 32'hA2, 32'hA3, -1, 0);

        repeat (2) @(negedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
